// File: rtl/load_store_unit.sv
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding load/store sequencer between a core
//                request/response port and a simple data memory.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STORE     = 3'd1,
    S_LOAD_ADDR = 3'd2,
    S_LOAD_DATA = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_state <= req_we ? S_STORE : S_LOAD_ADDR;
          end
        end
        S_STORE:     r_state <= S_IDLE;
        // Address is held through both load states, so a synchronous-read
        // memory has its data ready by the end of LOAD_DATA.
        S_LOAD_ADDR: r_state <= S_LOAD_DATA;
        S_LOAD_DATA: begin
          r_rdata <= mem_rdata;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  // Gating with rst keeps an aborted store from reaching memory.
  assign mem_we     = (r_state == S_STORE) & r_we & ~rst;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Randomized self-checking bench for load_store_unit against
//                a memory-array reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [3:0] req_wdata;
  logic       resp_valid;
  logic       resp_ready;
  logic [3:0] resp_rdata;
  logic       busy;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  // Memory attached to the DUT: write on clock edge, asynchronous read.
  logic [3:0] mem [16] = '{default: 4'h0};
  // Reference: what memory must hold, given the accepted stores.
  logic [3:0] ref_mem [16] = '{default: 4'h0};

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  load_store_unit #(.ADDR_W(4), .DATA_W(4)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .busy       (busy),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    if (!req_ready) check_val("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) bad++;
    check_val(tag, bad, 0);
  endtask

  // Store; accept edge is counted as cycle 1, ready expected at cycle 2.
  task automatic do_store(input logic [3:0] addr, input logic [3:0] data, input bit scramble);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
    tick();
    req_valid = 1'b0;
    if (scramble) begin
      req_addr  = addr ^ 4'hF;
      req_wdata = data ^ 4'h5;
    end
    check_val("st_we_c1",    mem_we,    1);
    check_val("st_addr_c1",  mem_addr,  addr);
    check_val("st_wdata_c1", mem_wdata, data);
    check_val("st_ready_c1", req_ready, 0);
    tick();
    ref_mem[addr] = data;
    check_val("st_we_c2",    mem_we,    0);
    check_val("st_ready_c2", req_ready, 1);
    check_val("st_mem",      mem[addr], data);
  endtask

  // Load; hold = cycles resp_ready stays low while the response is pending.
  task automatic do_load(input logic [3:0] addr, input int hold);
    int lat;
    logic [3:0] exp;
    exp = ref_mem[addr];
    wait_ready();
    resp_ready = (hold == 0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_wdata = 4'($urandom);
    tick();
    if (hold > 0) begin
      // A competing store kept valid must be ignored until the unit is idle.
      req_valid = 1'b1; req_we = 1'b1;
      req_addr = 4'($urandom); req_wdata = 4'($urandom);
    end else begin
      req_valid = 1'b0;
    end
    lat = 1;
    while (!resp_valid && lat < 8) begin
      check_val("ld_we_low",  mem_we,   0);
      check_val("ld_addr_hold", mem_addr, addr);
      tick();
      lat++;
    end
    check_val("ld_latency", lat, 3);
    check_val("ld_rdata", resp_rdata, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_val("ld_hold_valid", resp_valid, 1);
      check_val("ld_hold_rdata", resp_rdata, exp);
      check_val("ld_hold_ready", req_ready,  0);
    end
    resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check_val("ld_done_valid", resp_valid, 0);
    check_val("ld_done_busy",  busy,       0);
    check_val("ld_keep_rdata", resp_rdata, exp);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_val("rst_ready",  req_ready,  1);
    check_val("rst_busy",   busy,       0);
    check_val("rst_rvalid", resp_valid, 0);
    check_val("rst_we",     mem_we,     0);
    check_val("rst_addr",   mem_addr,   0);
    check_val("rst_wdata",  mem_wdata,  0);
    check_val("rst_rdata",  resp_rdata, 0);

    do_store(4'd5, 4'd7, 1'b0);
    do_load(4'd5, 0);
    do_store(4'd5, 4'd12, 1'b0);
    do_load(4'd5, 4);

    // Reset in the STORE cycle aborts the write.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 4'd3;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_val("abort_st_we", mem_we, 0);
    tick();
    rst = 1'b0;
    check_val("abort_st_idle", busy, 0);
    do_load(4'd5, 0);

    do_store(4'd2, 4'd9, 1'b1);
    compare_mem("mem_after_scramble");

    // Reset wins over a simultaneous request.
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
    tick();
    rst = 1'b0; req_valid = 1'b0;
    check_val("rst_prio_busy", busy, 0);

    // Reset during a pending load: no response may follow.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) seen = 1'b1;
      tick();
    end
    check_val("abort_ld_noresp", seen, 0);
    check_val("abort_ld_rdata", resp_rdata, 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1)
        do_store(4'($urandom), 4'($urandom), 1'($urandom));
      else
        do_load(4'($urandom), int'($urandom_range(0, 3)));
    end
    compare_mem("mem_final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
